// File: rtl/bpsk_rx_pkg.sv
// BPSK receiver shared constants, widths and lock FSM encoding.
// Imported by the integrator and the demodulator top.
package bpsk_rx_pkg;

  localparam int SAMPLES_PER_BIT = 833;
  localparam logic [7:0] SYNC_WORD = 8'b10010100;
  localparam int LOCK_MISS = 3;

  localparam int SAMPLE_W = 12;
  localparam int REF_W = 8;
  localparam int PROD_W = 20;
  localparam int ACC_W = 30;

  typedef enum logic {
    HUNT = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/bpsk_integrator.sv
// Integrate-and-dump correlator: multiply by the local carrier,
// accumulate over one bit period, slice the sign on the last sample.
module bpsk_integrator
  import bpsk_rx_pkg::*;
#(
  parameter int SPB = bpsk_rx_pkg::SAMPLES_PER_BIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [REF_W-1:0]    ref_sine,
  output logic                dump,
  output logic                dump_bit,
  output logic                bit_valid,
  output logic                bit_raw
);

  localparam int CW = (SPB > 1) ? $clog2(SPB) : 1;

  logic signed [SAMPLE_W-1:0] s;
  logic signed [REF_W-1:0]    r;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sum;
  logic [CW-1:0]              cnt;
  logic                       prod_v;
  logic                       prod_last;
  logic                       cnt_last;

  assign s = sample;
  assign r = ref_sine;
  assign cnt_last = (cnt == CW'(SPB - 1));
  assign sum = acc + ACC_W'(prod);
  assign dump = enable & prod_v & prod_last;
  assign dump_bit = ~sum[ACC_W-1];

  // Product pipeline, accumulate, sample count and dump strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
      prod_v <= 1'b0;
      prod_last <= 1'b0;
      acc <= '0;
      cnt <= '0;
      bit_valid <= 1'b0;
      bit_raw <= 1'b0;
    end else begin
      bit_valid <= dump;
      if (dump) bit_raw <= dump_bit;
      if (enable) begin
        prod_v <= sample_valid;
        if (sample_valid) begin
          prod <= PROD_W'(s) * PROD_W'(r);
          prod_last <= cnt_last;
          cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
        if (prod_v) acc <= prod_last ? '0 : sum;
      end
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK demodulator top: integrator plus sync-word hunt/lock FSM
// that resolves the 180-degree phase ambiguity.
module bpsk_demodulator
  import bpsk_rx_pkg::*;
#(
  parameter int         SAMPLES_PER_BIT = bpsk_rx_pkg::SAMPLES_PER_BIT,
  parameter logic [7:0] SYNC_WORD = bpsk_rx_pkg::SYNC_WORD,
  parameter int         LOCK_MISS = bpsk_rx_pkg::LOCK_MISS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [REF_W-1:0]    ref_sine,
  output logic                bit_valid,
  output logic                bit_raw,
  output logic                data_valid,
  output logic                data_bit,
  output logic                locked,
  output logic                inverted
);

  localparam int MW = $clog2(LOCK_MISS + 1);

  logic          dump;
  logic          dump_bit;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_nx;
  logic [7:0]    expect_w;
  logic [2:0]    frame_cnt;
  logic [MW-1:0] miss_cnt;
  state_t        state;

  bpsk_integrator #(
    .SPB(SAMPLES_PER_BIT)
  ) u_int (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_valid(sample_valid),
    .sample(sample),
    .ref_sine(ref_sine),
    .dump(dump),
    .dump_bit(dump_bit),
    .bit_valid(bit_valid),
    .bit_raw(bit_raw)
  );

  assign shift_nx = {dump_bit, shift_reg[7:1]};
  assign expect_w = inverted ? ~SYNC_WORD : SYNC_WORD;

  // Sync hunt and lock supervision, evaluated on each new decision
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
      shift_reg <= '0;
      frame_cnt <= '0;
      miss_cnt <= '0;
      data_valid <= 1'b0;
      data_bit <= 1'b0;
      locked <= 1'b0;
      inverted <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (dump) begin
        shift_reg <= shift_nx;
        unique case (state)
          HUNT: begin
            if (shift_nx == SYNC_WORD) begin
              state <= LOCKED;
              locked <= 1'b1;
              inverted <= 1'b0;
              frame_cnt <= '0;
              miss_cnt <= '0;
            end else if (shift_nx == ~SYNC_WORD) begin
              state <= LOCKED;
              locked <= 1'b1;
              inverted <= 1'b1;
              frame_cnt <= '0;
              miss_cnt <= '0;
            end
          end
          LOCKED: begin
            data_bit <= dump_bit ^ inverted;
            data_valid <= 1'b1;
            frame_cnt <= frame_cnt + 3'd1;
            if (frame_cnt == 3'd7) begin
              if (shift_nx == expect_w) begin
                miss_cnt <= '0;
              end else if (miss_cnt == MW'(LOCK_MISS - 1)) begin
                state <= HUNT;
                locked <= 1'b0;
                data_valid <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Randomized bench for bpsk_demodulator against a sum-and-compare
// model of bit decisions and sync-word lock behaviour.
module tb_bpsk_demodulator;

  localparam int SPB = 100;
  localparam logic [7:0] SYNC = 8'b10010100;
  localparam int LMISS = 3;

  logic clk = 1'b0;
  logic reset, enable, sample_valid;
  logic [11:0] sample;
  logic [7:0] ref_sine;
  logic bit_valid, bit_raw, data_valid, data_bit, locked, inverted;

  bpsk_demodulator #(
    .SAMPLES_PER_BIT(SPB),
    .SYNC_WORD(SYNC),
    .LOCK_MISS(LMISS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_valid(sample_valid),
    .sample(sample),
    .ref_sine(ref_sine),
    .bit_valid(bit_valid),
    .bit_raw(bit_raw),
    .data_valid(data_valid),
    .data_bit(data_bit),
    .locked(locked),
    .inverted(inverted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 0;
  int bv_seen, bv_cyc;
  bit dq[$];
  bit dec_q[$];

  longint m_sum;
  int m_cnt, since, misses;
  bit pend, pend_bit;
  bit exp_bv, exp_raw, exp_dv, exp_db, exp_lk, exp_inv;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] last8();
    logic [7:0] w;
    int idx;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      idx = dec_q.size() - 8 + i;
      if (idx >= 0) w[i] = dec_q[idx];
    end
    return w;
  endfunction

  function automatic logic [7:0] dq_word(input int start);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (start + i < dq.size()) w[i] = dq[start + i];
    return w;
  endfunction

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; since = 0; misses = 0;
    pend = 0; pend_bit = 0;
    exp_bv = 0; exp_raw = 0; exp_dv = 0; exp_db = 0;
    exp_lk = 0; exp_inv = 0;
    dec_q.delete();
  endtask

  task automatic model_bit(input bit b);
    logic [7:0] w;
    dec_q.push_back(b);
    w = last8();
    exp_bv = 1;
    exp_raw = b;
    if (!exp_lk) begin
      if (w == SYNC) begin
        exp_lk = 1; exp_inv = 0; since = 0; misses = 0;
      end else if (w == ~SYNC) begin
        exp_lk = 1; exp_inv = 1; since = 0; misses = 0;
      end
    end else begin
      exp_dv = 1;
      exp_db = b ^ exp_inv;
      since++;
      if (since % 8 == 0) begin
        if (w != (exp_inv ? ~SYNC : SYNC)) misses++;
        else misses = 0;
        if (misses == LMISS) begin
          exp_lk = 0; exp_dv = 0; misses = 0;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input int s, input int r,
                       input bit en, input bit rst);
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      check("bit_valid", bit_valid, exp_bv);
      check("bit_raw", bit_raw, exp_raw);
      check("data_valid", data_valid, exp_dv);
      if (exp_dv) check("data_bit", data_bit, exp_db);
      check("locked", locked, exp_lk);
      check("inverted", inverted, exp_inv);
    end
    if (bit_valid === 1'b1) begin
      bv_seen++;
      bv_cyc = cyc;
    end
    if (data_valid === 1'b1) dq.push_back(data_bit);
    reset = rst;
    enable = en;
    sample_valid = v;
    sample = 12'(s);
    ref_sine = 8'(r);
    exp_bv = 0;
    exp_dv = 0;
    if (rst) begin
      model_reset();
    end else if (en) begin
      if (pend) begin
        pend = 0;
        model_bit(pend_bit);
      end
      if (v) begin
        m_sum += longint'(s * r);
        m_cnt++;
        if (m_cnt == SPB) begin
          pend = 1;
          pend_bit = (m_sum >= 0);
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0);
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(4094)) - 2047;
  endfunction

  function automatic int rnd_r();
    return int'($urandom_range(254)) - 127;
  endfunction

  task automatic send_bit(input bit b, input bit neg, input int gap);
    int sgn, r, nz;
    sgn = (b ^ neg) ? 1 : -1;
    for (int i = 0; i < SPB; i++) begin
      if (gap > 0) begin
        while ($urandom_range(99) < gap)
          drive(0, rnd_s(), rnd_r(), 1, 0);
        if ($urandom_range(99) < 3)
          repeat ($urandom_range(1, 5))
            drive(1'($urandom_range(1)), rnd_s(), rnd_r(), 0, 0);
      end
      r = rnd_r();
      nz = int'($urandom_range(100)) - 50;
      drive(1, sgn * r * 10 + nz, r, 1, 0);
    end
  endtask

  task automatic send_byte(input logic [7:0] w, input bit neg,
                           input int gap);
    for (int i = 0; i < 8; i++) send_bit(w[i], neg, gap);
  endtask

  logic [7:0] pat, bad;
  int c0, kind;

  initial begin
    reset = 1; enable = 0; sample_valid = 0;
    sample = '0; ref_sine = '0;
    model_reset();
    repeat (3) drive(0, 0, 0, 0, 1);
    chk_en = 1;
    pat = SYNC;
    bad = SYNC ^ 8'h01;

    drive(0, 0, 0, 1, 0);
    check("reset_outs",
          {bit_valid, bit_raw, data_valid, data_bit, locked, inverted},
          6'b0);

    bv_seen = 0;
    for (int i = 0; i < SPB; i++) drive(1, 1000, 100, 1, 0);
    idle(3);
    check("const_strobes", bv_seen, 1);
    check("const_raw", bit_raw, 1);

    for (int i = 0; i < SPB; i++) drive(1, -1, 1, 1, 0);
    idle(3);
    check("acc_cleared_raw", bit_raw, 0);

    for (int i = 0; i < SPB; i++) drive(1, (i % 2) ? -5 : 5, 10, 1, 0);
    idle(3);
    check("zero_sum_raw", bit_raw, 1);

    drive(0, 0, 0, 1, 1);
    dq.delete();
    for (int i = 0; i < 7; i++) send_bit(pat[i], 0, 25);
    idle(2);
    check("prelock", locked, 0);
    send_bit(pat[7], 0, 25);
    idle(2);
    check("lock", locked, 1);
    check("lock_inv", inverted, 0);
    send_byte(pat, 0, 25);
    send_byte(pat, 0, 25);
    idle(2);
    check("data_word0", dq_word(0), SYNC);
    check("data_word1", dq_word(8), SYNC);

    drive(0, 0, 0, 1, 1);
    dq.delete();
    for (int k = 0; k < 3; k++) send_byte(pat, 1, 25);
    idle(2);
    check("nlock", locked, 1);
    check("nlock_inv", inverted, 1);
    check("ndata_word", dq_word(0), SYNC);

    send_byte(bad, 1, 10);
    send_byte(bad, 1, 10);
    send_byte(pat, 1, 10);
    idle(2);
    check("hold_lock", locked, 1);
    send_byte(bad, 1, 10);
    send_byte(bad, 1, 10);
    for (int i = 0; i < 7; i++) send_bit(bad[i], 1, 10);
    idle(2);
    check("predrop", locked, 1);
    send_bit(bad[7], 1, 10);
    idle(2);
    check("drop", locked, 0);
    check("drop_inv", inverted, 1);

    bv_seen = 0;
    c0 = 0;
    for (int i = 0; i < SPB + 50; i++) begin
      if (i >= 40 && i < 90) drive(1, -2000, 127, 0, 0);
      else drive(1, 800, 90, 1, 0);
      if (i == 0) c0 = cyc;
    end
    idle(3);
    check("pause_strobes", bv_seen, 1);
    check("pause_raw", bit_raw, 1);
    check("pause_time", bv_cyc - c0, SPB + 51);

    for (int i = 0; i < 40; i++) drive(1, 900, 100, 1, 0);
    drive(1, 900, 100, 1, 1);
    bv_seen = 0;
    for (int i = 0; i < SPB - 41; i++) drive(1, 900, 100, 1, 0);
    idle(3);
    check("rst_no_strobe", bv_seen, 0);
    check("rst_outs",
          {bit_valid, bit_raw, data_valid, data_bit, locked, inverted},
          6'b0);

    for (int run = 0; run < 2; run++) begin
      drive(0, 0, 0, 1, 1);
      for (int f = 0; f < 12; f++) begin
        kind = int'($urandom_range(3));
        if (kind < 2) send_byte(pat, 1'(run), 30);
        else if (kind == 2) send_byte(8'($urandom), 1'(run), 30);
        else send_byte(pat ^ (8'h01 << $urandom_range(7)), 1'(run), 30);
      end
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bpsk_demodulator.md
BPSK_DEMODULATOR -- requirements
Module: bpsk_demodulator

Interface
REQ-001 SHALL have parameter SAMPLES_PER_BIT, default 833, giving sample_valid strobes per bit period (2 MHz / 2400 bps).
REQ-002 SHALL have parameter SYNC_WORD, default 8'b10010100, giving the sync pattern, bit 0 transmitted first.
REQ-003 SHALL have parameter LOCK_MISS, default 3, giving consecutive mismatched 8-bit frames that drop lock.
REQ-004 SHALL have port clk, input, 1, the single clock. One clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1; when low, all state holds and no strobes issue.
REQ-007 SHALL have port sample_valid, input, 1, a strobe qualifying sample and ref_sine.
REQ-008 SHALL have port sample, input, 12, the signed received sample.
REQ-009 SHALL have port ref_sine, input, 8, the signed 48 kHz local carrier, phase-aligned.
REQ-010 SHALL have port bit_valid, output, 1, a one-cycle strobe for each hard decision.
REQ-011 SHALL have port bit_raw, output, 1, the un-derotated decision.
REQ-012 SHALL have port data_valid, output, 1, a one-cycle strobe for a phase-corrected bit, asserted only when locked.
REQ-013 SHALL have port data_bit, output, 1, the phase-corrected bit.
REQ-014 SHALL have port locked, output, 1, high while in the LOCKED state.
REQ-015 SHALL have port inverted, output, 1, high when the 180-degree BPSK ambiguity was resolved as inverted.

Function
REQ-016 SHALL register the product sample*ref_sine at full 20-bit signed width one cycle after a qualified sample_valid.
REQ-017 SHALL sum registered products into a 30-bit signed accumulator, with no saturation required (833*2048*128 < 2^29).
REQ-018 SHALL count samples 0..SAMPLES_PER_BIT-1 and wrap to 0 after the last sample.
REQ-019 SHALL, on the last sample of a period, dump: decide on acc+product, then clear acc to 0 so the next period starts clean.
REQ-020 SHALL set bit_raw=1 when the dumped sum >=0 and 0 when it is <0; exactly 0 decides 1.
REQ-021 SHALL assert bit_valid exactly 2 clk after the sample_valid of the last sample, for 1 cycle.
REQ-022 SHALL accept sample_valid on back-to-back cycles without loss.
REQ-023 SHALL shift each decision into an 8-bit register at bit 7, shifting right, so bit 0 holds the oldest.
REQ-024 SHALL implement the HUNT state: on every bit_valid, compare the shift register to SYNC_WORD and ~SYNC_WORD. A match goes to LOCKED with inverted=0; a complement match goes to LOCKED with inverted=1; the frame counter is set to 0 on the transition.
REQ-025 SHALL implement the LOCKED state: data_bit = bit_raw ^ inverted, with data_valid coincident with bit_valid. The first data_valid is the bit after the sync match.
REQ-026 SHALL, in LOCKED, count bits 0..7 and at each 8th bit compare the frame against the locked polarity. A mismatch increments miss_cnt; a match clears it.
REQ-027 SHALL, when miss_cnt reaches LOCK_MISS, return to HUNT, deassert locked and data_valid that cycle, and keep inverted unchanged until the next lock.
REQ-028 SHALL let enable low mid-period freeze the counter, accumulator and FSM; resuming continues the same period.
REQ-029 SHALL give reset priority over sample_valid and enable in the same cycle.

Reset
REQ-030 SHALL on reset clear to 0: accumulator, product register, sample counter, shift register, frame counter, miss_cnt, bit_valid, bit_raw, data_valid, data_bit, locked and inverted; the FSM SHALL go to HUNT.
REQ-031 SHALL make reset mid-period discard the partial integration, with no strobe issued for it.

Structure
REQ-032 SHALL place SAMPLES_PER_BIT, SYNC_WORD, LOCK_MISS, the width constants (12/8/20/30) and the FSM state encoding HUNT/LOCKED in shared package bpsk_rx_pkg.
REQ-033 SHALL implement multiply, accumulate, count and dump as sub-module bpsk_integrator; sync/lock FSM stays in the top.

Verification
REQ-034 SHALL verify: sample=+1000, ref=+100 constant for 833 strobes -> bit_valid once, bit_raw=1, 2 clk after the last strobe; acc cleared.
REQ-035 SHALL verify: BPSK stimulus of repeating 10010100 (LSB first), 833 samples per bit -> locked after 8 bits, inverted=0, data_bit reproduces the pattern.
REQ-036 SHALL verify: same stimulus with sample negated -> locked, inverted=1, data_bit equals the original pattern.
REQ-037 SHALL verify: after lock, 3 consecutive corrupted frames -> locked falls at the 24th bit; 2 corrupted then 1 good -> lock held.
REQ-038 SHALL verify: enable low for 50 cycles at sample 400 -> decision unchanged and timing shifted by 50 clk; reset at sample 400 -> no bit_valid for that period, all outputs 0.
REQ-039 SHALL verify: sum exactly 0 (alternating +/- products) -> bit_raw=1.
